// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronises the clock generator's lock flag, waits for a stable lock
// window, then releases core and peripheral resets in order; counts lock-loss events.
//
//  state      | meaning
//  -----------+--------------------------------------------------------------
//  ST_HOLD    | both resets asserted, waiting for synchronised lock
//  ST_STABLE  | lock seen, counting down the stable window (resets asserted)
//  ST_CORE_UP | core released, peripheral held for the stage delay
//  ST_RUN     | both resets released, sys_ready high
module reset_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 16,
    parameter int STAGE_DELAY        = 8,
    parameter int LOSS_CNT_W         = 8
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  locked,
    input  logic                  soft_reset,
    output logic                  rst_core,
    output logic                  rst_periph,
    output logic                  sys_ready,
    output logic [LOSS_CNT_W-1:0] loss_count
);

    localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int DW = $clog2(STAGE_DELAY + 1);

    // The HOLD cycle that first sees lock consumes one count, so a cold start loads the
    // full window; a soft restart already holds a sampled-high lock and loads one less.
    localparam logic [SW-1:0] STABLE_COLD   = SW'(LOCK_STABLE_CYCLES);
    localparam logic [SW-1:0] STABLE_RELOCK = SW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [DW-1:0] DELAY_LOAD    = DW'(STAGE_DELAY - 1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_STABLE  = 2'd1,
        ST_CORE_UP = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    state_t                  state, state_nxt;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    locked_s;
    logic                    soft_q;
    logic [SW-1:0]           stable_cnt, stable_nxt;
    logic [DW-1:0]           delay_cnt, delay_nxt;
    logic [LOSS_CNT_W-1:0]   loss_nxt;
    logic                    lock_lost;

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_nxt  = state;
        stable_nxt = stable_cnt;
        delay_nxt  = delay_cnt;
        loss_nxt   = loss_count;
        lock_lost  = 1'b0;

        case (state)
            ST_HOLD: begin
                if (!locked_s) begin
                    stable_nxt = STABLE_COLD;
                end else if (stable_cnt == '0) begin
                    state_nxt = ST_CORE_UP;
                    delay_nxt = DELAY_LOAD;
                end else begin
                    state_nxt  = ST_STABLE;
                    stable_nxt = stable_cnt - 1'b1;
                end
            end
            ST_STABLE: begin
                if (!locked_s) begin
                    state_nxt  = ST_HOLD;
                    stable_nxt = STABLE_COLD;
                end else if (soft_q) begin
                    state_nxt  = ST_HOLD;
                    stable_nxt = STABLE_RELOCK;
                end else if (stable_cnt == '0) begin
                    state_nxt = ST_CORE_UP;
                    delay_nxt = DELAY_LOAD;
                end else begin
                    stable_nxt = stable_cnt - 1'b1;
                end
            end
            ST_CORE_UP, ST_RUN: begin
                if (!locked_s) begin
                    lock_lost  = 1'b1;
                    state_nxt  = ST_HOLD;
                    stable_nxt = STABLE_COLD;
                    delay_nxt  = '0;
                end else if (soft_q) begin
                    state_nxt  = ST_HOLD;
                    stable_nxt = STABLE_RELOCK;
                    delay_nxt  = '0;
                end else if (state == ST_CORE_UP) begin
                    if (delay_cnt == '0) begin
                        state_nxt = ST_RUN;
                    end else begin
                        delay_nxt = delay_cnt - 1'b1;
                    end
                end
            end
            default: begin
                state_nxt  = ST_HOLD;
                stable_nxt = STABLE_COLD;
            end
        endcase

        if (lock_lost && (loss_count != '1)) begin
            loss_nxt = loss_count + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state      <= ST_HOLD;
            sync_q     <= '0;
            soft_q     <= 1'b0;
            stable_cnt <= STABLE_COLD;
            delay_cnt  <= '0;
            loss_count <= '0;
            rst_core   <= 1'b1;
            rst_periph <= 1'b1;
            sys_ready  <= 1'b0;
        end else begin
            state      <= state_nxt;
            sync_q     <= {sync_q[SYNC_STAGES-2:0], locked};
            soft_q     <= soft_reset;
            stable_cnt <= stable_nxt;
            delay_cnt  <= delay_nxt;
            loss_count <= loss_nxt;
            // outputs decoded from the next state so they change on the same edge as state
            rst_core   <= !((state_nxt == ST_CORE_UP) || (state_nxt == ST_RUN));
            rst_periph <= (state_nxt != ST_RUN);
            sys_ready  <= (state_nxt == ST_RUN);
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: event-time model of the release schedule checked every
// cycle, plus literal expectations at hand-computed edges relative to stimulus.
module tb_reset_sequencer;

    localparam int SYNC = 2;
    localparam int NST  = 16;
    localparam int DLY  = 8;
    localparam int LW   = 2;
    localparam int LMAX = (1 << LW) - 1;

    logic          clk = 1'b0;
    logic          reset_in = 1'b1;
    logic          locked = 1'b0;
    logic          soft_reset = 1'b0;
    logic          rst_core;
    logic          rst_periph;
    logic          sys_ready;
    logic [LW-1:0] loss_count;

    always #5 clk = ~clk;

    reset_sequencer #(
        .SYNC_STAGES(SYNC),
        .LOCK_STABLE_CYCLES(NST),
        .STAGE_DELAY(DLY),
        .LOSS_CNT_W(LW)
    ) dut (
        .clk_in(clk),
        .reset_in(reset_in),
        .locked(locked),
        .soft_reset(soft_reset),
        .rst_core(rst_core),
        .rst_periph(rst_periph),
        .sys_ready(sys_ready),
        .loss_count(loss_count)
    );

    int checks = 0;
    int failures = 0;

    // Model: edge index t, sampled lock history, and absolute edge at which each
    // reset is due to release (-1 when nothing is scheduled).
    int            t = 0;
    bit            model_valid = 1'b0;
    logic [SYNC-1:0] lk = '0;
    logic          soft_d = 1'b0;
    logic          m_core = 1'b1;
    logic          m_periph = 1'b1;
    logic          m_ready = 1'b0;
    int            m_loss = 0;
    int            tgt_core = -1;
    int            tgt_periph = -1;

    always @(posedge clk) begin
        t <= t + 1;
        if (reset_in) begin
            model_valid <= 1'b1;
            lk          <= '0;
            soft_d      <= 1'b0;
            m_core      <= 1'b1;
            m_periph    <= 1'b1;
            m_ready     <= 1'b0;
            m_loss      <= 0;
            tgt_core    <= -1;
            tgt_periph  <= -1;
        end else begin
            lk     <= {lk[SYNC-2:0], locked};
            soft_d <= soft_reset;
            if (!m_core && !lk[SYNC-1]) begin
                m_loss     <= (m_loss < LMAX) ? m_loss + 1 : m_loss;
                m_core     <= 1'b1;
                m_periph   <= 1'b1;
                m_ready    <= 1'b0;
                tgt_core   <= -1;
                tgt_periph <= -1;
            end else if (soft_d && lk[SYNC-1] && (!m_core || tgt_core >= 0)) begin
                m_core     <= 1'b1;
                m_periph   <= 1'b1;
                m_ready    <= 1'b0;
                tgt_core   <= t + 1 + NST;
                tgt_periph <= -1;
            end else if (m_core) begin
                if (!lk[SYNC-1]) begin
                    tgt_core <= -1;
                end else if (tgt_core < 0) begin
                    tgt_core <= t + 1 + NST;
                end else if (t + 1 == tgt_core) begin
                    m_core     <= 1'b0;
                    tgt_core   <= -1;
                    tgt_periph <= t + 1 + DLY;
                end
            end else if (t + 1 == tgt_periph) begin
                m_periph   <= 1'b0;
                m_ready    <= 1'b1;
                tgt_periph <= -1;
            end
        end
    end

    typedef struct {
        string name;
        int    sig;
        int    val;
        int    cyc;
    } lit_t;
    lit_t lits[$];

    function automatic void expect_lit(input string name, input int sig, input int val);
        lit_t e;
        e.name = name;
        e.sig  = sig;
        e.val  = val;
        e.cyc  = t;
        lits.push_back(e);
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, t, act, exp);
        end
    endtask

    always @(negedge clk) begin
        lit_t e;
        logic [31:0] act;
        #2;
        if (model_valid) begin
            cmp("model rst_core", 32'(rst_core), 32'(m_core));
            cmp("model rst_periph", 32'(rst_periph), 32'(m_periph));
            cmp("model sys_ready", 32'(sys_ready), 32'(m_ready));
            cmp("model loss_count", 32'(loss_count), 32'(m_loss));
            while (lits.size() > 0 && lits[0].cyc <= t) begin
                e = lits.pop_front();
                case (e.sig)
                    0:       act = 32'(rst_core);
                    1:       act = 32'(rst_periph);
                    2:       act = 32'(sys_ready);
                    default: act = 32'(loss_count);
                endcase
                cmp(e.name, act, 32'(e.val));
            end
        end
    end

    task automatic wait_until(input int e);
        while (t < e) @(negedge clk);
    endtask

    int e0, e1, e2, l0, s0, r0, le, ee;

    initial begin
        repeat (5) @(negedge clk);
        reset_in = 1'b0;
        repeat (20) @(negedge clk);
        expect_lit("idle rst_core", 0, 1);
        expect_lit("idle rst_periph", 1, 1);
        expect_lit("idle sys_ready", 2, 0);
        expect_lit("idle loss_count", 3, 0);

        // cold start
        locked = 1'b1;
        e0 = t + 1;
        wait_until(e0 + 17);
        expect_lit("cold core held E0+17", 0, 1);
        wait_until(e0 + 18);
        expect_lit("cold core released E0+18", 0, 0);
        expect_lit("cold periph held E0+18", 1, 1);
        wait_until(e0 + 25);
        expect_lit("cold periph held E0+25", 1, 1);
        wait_until(e0 + 26);
        expect_lit("cold periph released E0+26", 1, 0);
        expect_lit("cold ready E0+26", 2, 1);

        // glitch during the stable window
        reset_in = 1'b1;
        locked = 1'b0;
        repeat (3) @(negedge clk);
        reset_in = 1'b0;
        repeat (3) @(negedge clk);
        locked = 1'b1;
        e0 = t + 1;
        wait_until(e0 + 9);
        locked = 1'b0;
        wait_until(e0 + 10);
        locked = 1'b1;
        e1 = t + 1;
        wait_until(e1 + 17);
        expect_lit("glitch core held E1+17", 0, 1);
        expect_lit("glitch loss_count", 3, 0);
        wait_until(e1 + 18);
        expect_lit("glitch core released E1+18", 0, 0);
        wait_until(e1 + 26);
        expect_lit("glitch ready E1+26", 2, 1);

        // lock loss in RUN
        locked = 1'b0;
        l0 = t + 1;
        wait_until(l0 + 1);
        expect_lit("loss core still up L0+1", 0, 0);
        expect_lit("loss ready still up L0+1", 2, 1);
        wait_until(l0 + 2);
        expect_lit("loss core L0+2", 0, 1);
        expect_lit("loss periph L0+2", 1, 1);
        expect_lit("loss ready L0+2", 2, 0);
        expect_lit("loss count L0+2", 3, 1);
        wait_until(l0 + 5);
        locked = 1'b1;
        e2 = t + 1;
        wait_until(e2 + 25);
        expect_lit("relock ready low E2+25", 2, 0);
        wait_until(e2 + 26);
        expect_lit("relock ready E2+26", 2, 1);

        // soft reset in RUN
        repeat (3) @(negedge clk);
        soft_reset = 1'b1;
        s0 = t + 1;
        wait_until(s0);
        soft_reset = 1'b0;
        expect_lit("soft core still up at S", 0, 0);
        wait_until(s0 + 1);
        expect_lit("soft core S+1", 0, 1);
        expect_lit("soft periph S+1", 1, 1);
        expect_lit("soft ready S+1", 2, 0);
        expect_lit("soft loss unchanged", 3, 1);
        wait_until(s0 + 16);
        expect_lit("soft core held S+16", 0, 1);
        wait_until(s0 + 17);
        expect_lit("soft core released S+17", 0, 0);
        wait_until(s0 + 25);
        expect_lit("soft ready S+25", 2, 1);

        // five more losses saturate the 2-bit counter
        for (int k = 0; k < 5; k++) begin
            locked = 1'b0;
            le = t + 1;
            wait_until(le + 2);
            expect_lit("sat loss_count", 3, (2 + k > LMAX) ? LMAX : 2 + k);
            wait_until(le + 4);
            locked = 1'b1;
            ee = t + 1;
            wait_until(ee + 18);
            expect_lit("sat core_up core", 0, 0);
            expect_lit("sat core_up periph", 1, 1);
        end

        // reset_in mid-CORE_UP
        reset_in = 1'b1;
        r0 = t + 1;
        wait_until(r0);
        reset_in = 1'b0;
        expect_lit("abort loss_count", 3, 0);
        expect_lit("abort core", 0, 1);
        expect_lit("abort periph", 1, 1);
        expect_lit("abort ready", 2, 0);
        wait_until(r0 + 18);
        expect_lit("post-abort core held", 0, 1);
        wait_until(r0 + 19);
        expect_lit("post-abort core released", 0, 0);

        repeat (3) @(negedge clk);
        #4;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Sequences system resets from the clock generator's `locked` indication. Sits directly downstream of `clk_gen`, clocked by its `clk_sys` output. Synchronises `locked`, requires it to stay high for a programmable stable window, then releases core and peripheral resets in order. Re-asserts both resets on lock loss or software request and counts lock-loss events.

## Interface
- `SYNC_STAGES`, 2: flops in the `locked` synchroniser chain (minimum 2).
- `LOCK_STABLE_CYCLES`, 16: consecutive synchronised-high cycles required before core reset release (minimum 1).
- `STAGE_DELAY`, 8: cycles between core and peripheral reset release (minimum 1).
- `LOSS_CNT_W`, 8: width of the lock-loss counter.

Ports:
- `clk_in`  input  1: block clock, connected to `clk_gen.clk_sys`; one clock domain.
- `reset_in`  input  1: synchronous, active-high reset.
- `locked`  input  1: asynchronous lock status from `clk_gen`.
- `soft_reset`  input  1: synchronous one-cycle request to re-run the sequence.
- `rst_core`  output  1: active-high core reset.
- `rst_periph`  output  1: active-high peripheral reset.
- `sys_ready`  output  1: high when both resets are released.
- `loss_count`  output  `LOSS_CNT_W`: saturating count of lock-loss events.

## Operation
- `locked` passes through `SYNC_STAGES` flops. `locked_s` is the last flop. All decisions use `locked_s` only.
- FSM states: HOLD, STABLE, CORE_UP, RUN.
- HOLD:
  - `rst_core=1`, `rst_periph=1`, `sys_ready=0`.
  - `locked_s=1` → STABLE.
- STABLE:
  - Resets stay asserted. A stable counter counts consecutive `locked_s=1` cycles.
  - `locked_s=0` → HOLD and counter cleared. This is not a loss event.
  - Count reaching `LOCK_STABLE_CYCLES` → CORE_UP.
- CORE_UP:
  - `rst_core=0`, `rst_periph=1`. A delay counter runs.
  - After `STAGE_DELAY` cycles → RUN.
- RUN: `rst_core=0`, `rst_periph=0`, `sys_ready=1`.
- Lock loss is `locked_s=0` in CORE_UP or RUN:
  - → HOLD.
  - `loss_count` increments, saturating at all-ones.
- `soft_reset=1` in STABLE, CORE_UP or RUN → HOLD with counters cleared. `loss_count` does not change.
- `soft_reset` in HOLD is ignored.
- Lock loss and `soft_reset` in the same cycle → HOLD, and the loss is counted.
- All outputs are registered, with no combinational path from `locked` or `soft_reset` to any output.
- `reset_in=1`:
  - State → HOLD.
  - Synchroniser flops, stable counter, delay counter and `loss_count` cleared.
  - Takes priority over every other input.
  - Mid-sequence `reset_in` aborts immediately.

## Timing
- Reset values: `rst_core=1`, `rst_periph=1`, `sys_ready=0`, `loss_count=0`.
- Let E0 be the first edge at which the first synchroniser flop samples `locked=1`, with `locked` held high from then on.
- `rst_core` falls at edge E0+`SYNC_STAGES`+`LOCK_STABLE_CYCLES`. Defaults: E0+18.
- `rst_periph` falls and `sys_ready` rises together at the core release edge + `STAGE_DELAY`. Defaults: E0+26.
- Let L0 be the first edge sampling `locked=0` while in CORE_UP or RUN.
  - `rst_core=1`, `rst_periph=1` and `sys_ready=0` at edge L0+`SYNC_STAGES`.
  - `loss_count` updates on that same edge.
- `soft_reset` sampled high at edge S:
  - Resets asserted and `sys_ready` low at edge S+1.
  - If `locked_s` remains high, the sequence restarts: `rst_core` falls at S+1+`LOCK_STABLE_CYCLES`.
- Glitch handling: any single synchronised-low cycle during STABLE restarts the full stable window.
- `rst_core=0` with `rst_periph=1` only ever occurs in CORE_UP. `rst_periph=0` with `rst_core=1` never occurs.

## Test plan
- Defaults. `reset_in` high 5 cycles, then `locked` held 0 for 20 cycles → `rst_core=1`, `rst_periph=1`, `sys_ready=0`, `loss_count=0` throughout.
- `locked` rises, first sampled at E0 → `rst_core` falls at E0+18, `rst_periph` falls and `sys_ready` rises at E0+26. Check both outputs are stable before those edges.
- In STABLE, drive `locked` low for 1 cycle at E0+10, then high again (first resampled high at E1) → no release before E1+18, and `loss_count` stays 0.
- In RUN, drop `locked` at L0 → all resets asserted and `sys_ready=0` at L0+2, `loss_count=1`. Restore `locked` → full re-sequence, `sys_ready` high 26 cycles after re-lock is sampled.
- In RUN, pulse `soft_reset` at S → resets asserted at S+1, `loss_count` unchanged, `rst_core` falls at S+17.
- With `LOSS_CNT_W=2`, force 5 lock losses → `loss_count` saturates at 3. Then `reset_in` mid-CORE_UP → `loss_count=0`, state HOLD, both resets asserted next edge.
